// File: rtl/tt_stim_pkg.sv
// Shared types and helpers for the stimulus sequencer / response capture unit.
// Holds the mode and state encodings, the Galois LFSR tap constants and the
// single-step LFSR helper used by both the pattern generator and the MISR.
package tt_stim_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Right-shifting Galois step; an 8-bit value lives in the low byte with the
  // upper byte zero, so the same routine serves both supported widths.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic wide);
    logic [15:0] taps;
    taps = wide ? LFSR_TAPS_16 : {8'h00, LFSR_TAPS_8};
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

endpackage

// File: rtl/tt_stim_capture_patgen.sv
// Pattern generator: count, Galois LFSR or walking-one sequence.
// load latches the mode and presents pattern 0; advance steps to the next one.
module tt_stim_capture_patgen
  import tt_stim_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] value_q, value_d;

  // Next pattern: load selects pattern 0 of the requested mode, advance steps it.
  always_comb begin
    mode_d  = mode_q;
    value_d = value_q;
    if (load) begin
      mode_d = mode_e'(mode);
      case (mode_e'(mode))
        MODE_LFSR: value_d = SEED;
        MODE_WALK: value_d = WIDTH'(1);
        default:   value_d = '0;
      endcase
    end else if (advance) begin
      case (mode_q)
        MODE_LFSR: value_d = WIDTH'(lfsr_step(16'(value_q), WIDTH == 16));
        MODE_WALK: value_d = {value_q[WIDTH-2:0], value_q[WIDTH-1]};
        default:   value_d = value_q + WIDTH'(1);
      endcase
    end
  end

  // Pattern and latched-mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_COUNT;
      value_q <= '0;
    end else begin
      mode_q  <= mode_d;
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/tt_stim_capture.sv
// Stimulus sequencer and response capture unit for on-chip self-test.
// Drives a pattern stream, samples the response LAT cycles later, keeps the
// first DEPTH responses for readout in DONE. Define TT_STIM_MISR_EN to fold
// every response into a MISR signature; otherwise signature reads 0.
module tt_stim_capture
  import tt_stim_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 16,
  parameter int               LEN_W = 8,
  parameter int               LAT   = 1,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [LEN_W-1:0]           length,
  output logic [WIDTH-1:0]           stim_out,
  input  logic [WIDTH-1:0]           resp_in,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     cap_count,
  output logic [WIDTH-1:0]           signature
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [1:0]     LAT_M1  = 2'(LAT - 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [LAT-1:0]    tag_q, tag_d;
  logic [LAT:0]      tag_ext;
  logic [CW-1:0]     cap_count_q, cap_count_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  pg_value;
  logic              pg_load, in_run, capture, wr_en, pop;

  tt_stim_capture_patgen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_patgen (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .load    (pg_load),
    .advance (in_run),
    .value   (pg_value)
  );

  assign in_run   = (state_q == ST_RUN);
  assign busy     = in_run || (state_q == ST_WAIT);
  assign done     = (state_q == ST_DONE);
  assign stim_out = in_run ? pg_value : '0;
  assign capture  = tag_q[LAT-1];
  assign wr_en    = capture && (cap_count_q < DEPTH_C);
  assign rd_valid = done && (rd_ptr_q != cap_count_q);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign cap_count = cap_count_q;

  // Valid pipe: a tag enters for every stimulus cycle and emerges LAT cycles later.
  assign tag_ext = {tag_q, in_run};
  assign tag_d   = tag_ext[LAT-1:0];

  // Sequencer next state; an accepted start overrides capture/pop bookkeeping.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wcnt_d      = wcnt_q;
    cap_count_d = cap_count_q;
    rd_ptr_d    = rd_ptr_q;
    pg_load     = 1'b0;
    if (wr_en) cap_count_d = cap_count_q + CW'(1);
    if (pop)   rd_ptr_d    = rd_ptr_q + CW'(1);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pg_load     = 1'b1;
          rem_d       = length;
          wcnt_d      = 2'd0;
          cap_count_d = '0;
          rd_ptr_d    = '0;
          state_d     = (length == '0) ? ST_WAIT : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_WAIT;
          wcnt_d  = 2'd0;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      ST_WAIT: begin
        if (wcnt_q == LAT_M1) state_d = ST_DONE;
        else                  wcnt_d  = wcnt_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer, pipe and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      wcnt_q      <= '0;
      tag_q       <= '0;
      cap_count_q <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wcnt_q      <= wcnt_d;
      tag_q       <= tag_d;
      cap_count_q <= cap_count_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Capture buffer; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cap_count_q[AW-1:0]] <= resp_in;
  end

`ifdef TT_STIM_MISR_EN
  logic [WIDTH-1:0] sig_q, sig_d;

  // MISR folds every emerging response, even once the buffer is full.
  always_comb begin
    sig_d = sig_q;
    if (pg_load)      sig_d = '0;
    else if (capture) sig_d = WIDTH'(lfsr_step(16'(sig_q), WIDTH == 16)) ^ resp_in;
  end

  // Signature register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_tt_stim_capture.sv
// Self-checking bench for tt_stim_capture (WIDTH=8, DEPTH=16, LAT=1).
// The response side is a registered DUT: resp_in = stim_out ^ mask, one cycle late.
module tb_tt_stim_capture;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [7:0]   length;
  logic [W-1:0] stim_out;
  logic [W-1:0] resp_in;
  logic         busy, done, rd_valid, rd_ready;
  logic [W-1:0] rd_data;
  logic [4:0]   cap_count;
  logic [W-1:0] signature;
  logic [W-1:0] mask;
  logic [W-1:0] obs_stim [64];

  int checks = 0;
  int errors = 0;

  tt_stim_capture #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .LEN_W (8),
    .LAT   (LAT),
    .SEED  (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .length    (length),
    .stim_out  (stim_out),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .cap_count (cap_count),
    .signature (signature)
  );

  always #5 clk = ~clk;

  // Registered user design stand-in.
  always @(posedge clk) resp_in <= stim_out ^ mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // Pattern k straight from the mode rules.
  function automatic logic [7:0] model_pat(input int m, input int k);
    logic [7:0] v;
    case (m)
      1: begin
        v = 8'h01;
        for (int i = 0; i < k; i++) v = lfsr_next(v);
      end
      2: v = 8'(1 << (k % W));
      default: v = 8'(k % 256);
    endcase
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_stim"}, stim_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_rdd"}, rd_data, 0);
    chk({tag, "_cnt"}, cap_count, 0);
    chk({tag, "_sig"}, signature, 0);
  endtask

  // One complete run: start, per-cycle stimulus, completion timing, readout.
  task automatic run(input int m, input int len, input logic [7:0] msk,
                     input int hold, input bit poke);
    logic [7:0] exp_resp [$];
    logic [7:0] sig_exp;
    logic [7:0] r;
    int n_exp, i, cyc;
    n_exp   = (len < DEPTH) ? len : DEPTH;
    sig_exp = 8'h00;
    for (int k = 0; k < len; k++) begin
      r = model_pat(m, k) ^ msk;
      if (k < DEPTH) exp_resp.push_back(r);
      sig_exp = lfsr_next(sig_exp) ^ r;
    end
`ifndef TT_STIM_MISR_EN
    sig_exp = 8'h00;
`endif
    $display("run mode=%0d len=%0d mask=%02h hold=%0d poke=%0d", m, len, msk, hold, poke);
    mask = msk; mode = 2'(m); length = 8'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk("run_busy", busy, 1);
      chk("run_stim", stim_out, model_pat(m, k));
      obs_stim[k] = stim_out;
      if (poke && k == 1) begin
        start = 1'b1; mode = 2'(m + 1); length = 8'd3;
      end
      @(negedge clk);
      start = 1'b0;
    end
    for (int w = 0; w < LAT; w++) begin
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
      chk("wait_stim", stim_out, 0);
      @(negedge clk);
    end
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    chk("done_stim", stim_out, 0);
    chk("cap_count", cap_count, n_exp);
    chk("signature", signature, sig_exp);
    i = 0; cyc = 0;
    while (i < n_exp && cyc < 200) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, exp_resp[i]);
      rd_ready = (cyc < hold) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rd_ready) i++;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("drain_all", i, n_exp);
    chk("empty_rdv", rd_valid, 0);
    chk("drain_cnt", cap_count, n_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; length = 8'd0; rd_ready = 1'b0; mask = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Count mode with three cycles of back-pressure before draining.
    run(0, 4, 8'h00, 3, 1'b0);
    // LFSR sequence from seed 1.
    run(1, 3, 8'h00, 0, 1'b0);
    chk("lfsr_p0", obs_stim[0], 8'h01);
    chk("lfsr_p1", obs_stim[1], 8'hB8);
    chk("lfsr_p2", obs_stim[2], 8'h5C);
    // Walking-one past buffer depth.
    run(2, 20, 8'h00, 0, 1'b0);
    // Zero-length run.
    run(0, 0, 8'h00, 0, 1'b0);

    // Asynchronous reset in the middle of a run.
    $display("reset mid-run");
    mask = 8'h00; mode = 2'd0; length = 8'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1, 12, 8'h3C, 1, 1'b0);

    // Randomized runs, some with a start pulse while busy.
    for (int t = 0; t < 8; t++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
          8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
